// File: rtl/aes_pkg.sv
// Shared AES constants and lookup helpers used by the forward and inverse key schedules.
`default_nettype none

package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;

    localparam logic [1:0] IKS_IDLE  = 2'd0;
    localparam logic [1:0] IKS_SERVE = 2'd1;
    localparam logic [1:0] IKS_DONE  = 2'd2;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[2047 - 8 * int'(b) -: 8];
    endfunction

    // Index 0 and 11..15 never occur in a legal schedule and return zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_word.sv
// Combinational SubWord: S-box applied to each of four bytes.
`default_nettype none

module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] subst
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign subst[8*i +: 8] = sbox(word[8*i +: 8]);
    end

endmodule

`default_nettype wire

// File: rtl/inv_key_schedule.sv
// On-the-fly inverse AES-128 key schedule: serves round keys 10 down to 0 from the final key.
`default_nettype none

module inv_key_schedule
    import aes_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic [KEY_W-1:0]   IKS_i_Key,
    input  logic               IKS_i_fStart,
    input  logic               IKS_i_fNext,
    output logic [KEY_W-1:0]   IKS_o_RoundKey,
    output logic [3:0]         IKS_o_Round,
    output logic               IKS_o_fValid,
    output logic               IKS_o_fBusy,
    output logic               IKS_o_fDone
);

    localparam logic [3:0] C_LAST_ROUND = 4'(NUM_ROUNDS);

    logic [1:0]       r_state;
    logic [KEY_W-1:0] r_key;
    logic [3:0]       r_round;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [31:0]      w_w0, w_w1, w_w2, w_w3;
    logic [31:0]      w_p0, w_p1, w_p2, w_p3;
    logic [31:0]      w_sub;
    logic [KEY_W-1:0] w_prev_key;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;

    // Undo the forward XOR chain first; p3 equals the previous key's w3, which feeds g().
    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;

    sub_word u_sub_word (
        .word  ({w_p3[23:0], w_p3[31:24]}),
        .subst (w_sub)
    );

    assign w_p0       = w_w0 ^ w_sub ^ {rcon(r_round), 24'h0};
    assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IKS_IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IKS_IDLE: begin
                    if (IKS_i_fStart) begin
                        r_key   <= IKS_i_Key;
                        r_round <= C_LAST_ROUND;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= IKS_SERVE;
                    end
                end
                IKS_SERVE: begin
                    if (IKS_i_fNext) begin
                        if (r_round != 4'd0) begin
                            r_key   <= w_prev_key;
                            r_round <= r_round - 4'd1;
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IKS_DONE;
                        end
                    end
                end
                IKS_DONE: begin
                    r_state <= IKS_IDLE;
                end
                default: begin
                    r_state <= IKS_IDLE;
                end
            endcase
        end
    end

    assign IKS_o_RoundKey = r_key;
    assign IKS_o_Round    = r_round;
    assign IKS_o_fValid   = r_valid;
    assign IKS_o_fBusy    = r_busy;
    assign IKS_o_fDone    = r_done;

endmodule

`default_nettype wire
